data_memory: RTL and testbench

Word-addressed 64 x 32-bit data memory for the processor datapath, sitting on the load/store path behind the ALU address output. Reads are combinational from the word index in address bits [7:2]. Writes are synchronous on the rising clock edge. All other address bits are ignored, so the array aliases across the whole 32-bit address space.

---
 rtl/data_memory.sv | 67 ++++++
 tb/tb_data_memory.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed DEPTH x 32-bit data memory: combinational read, synchronous write, async clear.
// Optional byte write strobes (port be_i) are enabled by defining DM_BYTE_WE_EN.
module data_memory #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  input  logic        we_i,
`ifdef DM_BYTE_WE_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] rd_o
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wdata;
  logic          w_unused;

`ifdef DM_BYTE_WE_EN
  // Lane-wise merge: strobed bytes come from the new data, the rest keep the stored word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strobes);
    logic [31:0] result;
    result = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strobes[k]) begin
        result[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        result[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return result;
  endfunction
`endif

  // Address bits outside the word index are deliberately ignored, so the array aliases.
  assign w_unused = ^{a_i[31:AW+2], a_i[1:0]};

  // Word index decode and write-data formation.
  always_comb begin
    w_idx   = a_i[AW+1:2];
`ifdef DM_BYTE_WE_EN
    w_wdata = merge_lanes(r_mem[w_idx], wd_i, be_i);
`else
    w_wdata = wd_i;
`endif
  end

  // Storage: reset clears every word at once and blocks writes; otherwise write on we_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (we_i) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  assign rd_o = r_mem[w_idx];

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: behavioural array model plus directed literal checks.
// Build with DM_BYTE_WE_EN defined to exercise the byte-strobe variant.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [3:0]  be;
  logic [31:0] rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [64];
  bit          model_valid = 1'b0;

  data_memory #(.DEPTH(64)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .a_i   (a),
    .wd_i  (wd),
    .we_i  (we),
`ifdef DM_BYTE_WE_EN
    .be_i  (be),
`endif
    .rd_o  (rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: array of words, cleared by reset, written on rising edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      model_valid = 1'b1;
    end else if (we) begin
`ifdef DM_BYTE_WE_EN
      for (int k = 0; k < 4; k++)
        if (be[k]) model_mem[a[7:2]][8*k +: 8] = wd[8*k +: 8];
`else
      model_mem[a[7:2]] = wd;
`endif
    end
  end

  // Continuous compare on the falling edge, away from the write edge.
  always @(negedge clk) begin
    if (model_valid) check("model", rd, model_mem[a[7:2]]);
  end

  task automatic edge_then_settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0; be = 4'hF;
    #12;
    check("reset_a0", rd, 32'h0);
    a = 32'h0000_00FC; #1;
    check("reset_aFC", rd, 32'h0);
    edge_then_settle();
    rst_n = 1'b1;

    // Write and read back through aliases
    a = 32'h7100_0010; wd = 32'd333; we = 1'b1;
    edge_then_settle();
    we = 1'b0; #1;
    check("wr_333", rd, 32'd333);
    a = 32'h7100_0011; #1; check("alias_low", rd, 32'd333);
    a = 32'h0000_0010; #1; check("alias_zero", rd, 32'd333);
    a = 32'hFFFF_FF10; #1; check("alias_high", rd, 32'd333);
    a = 32'h0000_0014; #1; check("neighbour", rd, 32'h0);

    // Write gating
    a = 32'h0000_0020; wd = 32'hDEAD_BEEF; we = 1'b0;
    repeat (3) edge_then_settle();
    check("gated", rd, 32'h0);
    we = 1'b1;
    edge_then_settle();
    we = 1'b0; #1;
    check("ungated", rd, 32'hDEAD_BEEF);

    // Read-during-write, then mid-cycle reset with a pending write
    a = 32'h0000_0010; wd = 32'd7; we = 1'b1; #1;
    check("rdw_old", rd, 32'd333);
    @(posedge clk); #1;
    check("rdw_new", rd, 32'd7);
    wd = 32'd99; #1;
    rst_n = 1'b0; #1;
    check("async_rst", rd, 32'h0);
    a = 32'h0000_0020; #1;
    check("async_rst_w8", rd, 32'h0);
    a = 32'h0000_0010;
    @(posedge clk); #1;
    check("rst_blocks_wr", rd, 32'h0);
    #1; rst_n = 1'b1; we = 1'b0;

    // First edge after release may write
    a = 32'h0000_0008; wd = 32'd55; we = 1'b1;
    edge_then_settle();
    we = 1'b0; #1;
    check("first_after_rst", rd, 32'd55);

    // Back-to-back writes to one word: last wins
    a = 32'h0000_000C; wd = 32'd1; we = 1'b1;
    edge_then_settle();
    wd = 32'd2;
    edge_then_settle();
    we = 1'b0; #1;
    check("b2b_last", rd, 32'd2);

`ifdef DM_BYTE_WE_EN
    a = 32'h0; wd = 32'h1122_3344; be = 4'hF; we = 1'b1;
    edge_then_settle();
    wd = 32'hAABB_CCDD; be = 4'b0101;
    edge_then_settle();
    we = 1'b0; #1;
    check("be_0101", rd, 32'h11BB_33DD);
    be = 4'b0000; we = 1'b1; wd = 32'hFFFF_FFFF;
    edge_then_settle();
    we = 1'b0; be = 4'hF; #1;
    check("be_none", rd, 32'h11BB_33DD);
`else
    a = 32'h0; wd = 32'h1122_3344; we = 1'b1;
    edge_then_settle();
    wd = 32'hAABB_CCDD;
    edge_then_settle();
    we = 1'b0; #1;
    check("full_word", rd, 32'hAABB_CCDD);
`endif

    // Sweep: distinct patterns through aliased addresses, then read every word
    for (int i = 0; i < 64; i += 5) begin
      a = (32'(i) << 2) | (32'(i) << 12) | 32'(i & 3);
      wd = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      we = 1'b1;
      edge_then_settle();
    end
    we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a = 32'(i) << 2;
      edge_then_settle();
    end
    a = 32'h0000_0014; #1;
    check("sweep_w5", rd, 32'hA5A5_0000 ^ 32'h0505_0505);
    a = 32'h0000_00FC; #1;
    check("sweep_w63", rd, 32'h0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
